ssp_tx_fifo: RTL and testbench

- Transmit-side FIFO of the SSP peripheral, the counterpart of the receive FIFO.
- Accepts bytes from the APB side, where a write is psel & pwrite, and holds them in order.
- Presents the oldest byte to the SSP transmit shifter, which pops it with a one-cycle strobe.
- Raises ssptxintr while full so the host stops writing.

---
 rtl/ssp_pkg.sv | 6 +
 rtl/fifo_ptr_ctrl.sv | 63 ++++++
 rtl/ssp_tx_fifo.sv | 56 +++++
 tb/tb_ssp_tx_fifo.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ssp_pkg.sv
// rtl/ssp_pkg.sv - shared SSP constants for the transmit and receive FIFOs
package ssp_pkg;
  localparam int SSP_DWIDTH     = 8;
  localparam int SSP_FIFO_DEPTH = 4;
  localparam int SSP_PTR_W      = 2;
endpackage

// File: rtl/fifo_ptr_ctrl.sv
// rtl/fifo_ptr_ctrl.sv - FIFO pointers, occupancy, accept logic and flags
// Optional SSP_TX_FIFO_ERR_EN adds sticky overflow/underflow flags.
module fifo_ptr_ctrl #(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          push_req,
  input  logic          pop_req,
  output logic          push_acc,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
`ifdef SSP_TX_FIFO_ERR_EN
  ,
  output logic          ovf,
  output logic          udf
`endif
);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic pop_acc;

  assign empty    = (count == '0);
  assign full     = (count == CNT_FULL);
  assign pop_acc  = pop_req & ~empty;
  // A full FIFO makes room only when a pop retires the head in the same cycle.
  assign push_acc = push_req & (~full | pop_acc);

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_acc)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_acc, pop_acc})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

`ifdef SSP_TX_FIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (clear) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (push_req & ~push_acc) ovf <= 1'b1;
      if (pop_req & empty)      udf <= 1'b1;
    end
  end
`endif
endmodule

// File: rtl/ssp_tx_fifo.sv
// rtl/ssp_tx_fifo.sv - SSP transmit FIFO: storage array and head-of-FIFO mux
// Optional SSP_TX_FIFO_ERR_EN exposes tx_ovf/tx_udf sticky error flags.
module ssp_tx_fifo
  import ssp_pkg::*;
#(
  parameter  int DEPTH  = SSP_FIFO_DEPTH,
  parameter  int DWIDTH = SSP_DWIDTH,
  localparam int PW     = $clog2(DEPTH),
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic              pclk,
  input  logic              clear,
  input  logic              psel,
  input  logic              pwrite,
  input  logic [DWIDTH-1:0] pwdata,
  input  logic              tx_rd,
  output logic [DWIDTH-1:0] txdata,
  output logic              tx_empty,
  output logic              ssptxintr,
  output logic [CW-1:0]     tx_count
`ifdef SSP_TX_FIFO_ERR_EN
  ,
  output logic              tx_ovf,
  output logic              tx_udf
`endif
);
  logic [DWIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              push_acc;

  fifo_ptr_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk      (pclk),
    .clear    (clear),
    .push_req (psel & pwrite),
    .pop_req  (tx_rd),
    .push_acc (push_acc),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .count    (tx_count),
    .empty    (tx_empty),
    .full     (ssptxintr)
`ifdef SSP_TX_FIFO_ERR_EN
    ,
    .ovf      (tx_ovf),
    .udf      (tx_udf)
`endif
  );

  // Storage is not reset; the empty flag masks stale contents on txdata.
  always_ff @(posedge pclk) begin
    if (push_acc) mem[wr_ptr] <= pwdata;
  end

  assign txdata = tx_empty ? '0 : mem[rd_ptr];
endmodule

// File: tb/tb_ssp_tx_fifo.sv
// tb/tb_ssp_tx_fifo.sv - directed self-checking bench for ssp_tx_fifo
module tb_ssp_tx_fifo;
  logic       pclk = 1'b0;
  logic       clear = 1'b1;
  logic       psel = 1'b0;
  logic       pwrite = 1'b0;
  logic [7:0] pwdata = 8'h00;
  logic       tx_rd = 1'b0;
  logic [7:0] txdata;
  logic       tx_empty;
  logic       ssptxintr;
  logic [2:0] tx_count;
`ifdef SSP_TX_FIFO_ERR_EN
  logic       tx_ovf;
  logic       tx_udf;
`endif

  int tests = 0;
  int fails = 0;
  logic [7:0] model_q[$];

  ssp_tx_fifo dut (
    .pclk      (pclk),
    .clear     (clear),
    .psel      (psel),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .tx_rd     (tx_rd),
    .txdata    (txdata),
    .tx_empty  (tx_empty),
    .ssptxintr (ssptxintr),
    .tx_count  (tx_count)
`ifdef SSP_TX_FIFO_ERR_EN
    ,
    .tx_ovf    (tx_ovf),
    .tx_udf    (tx_udf)
`endif
  );

  always #5 pclk = ~pclk;

  task automatic cyc(input logic s, input logic w, input logic [7:0] d,
                     input logic r, input logic c);
    psel = s; pwrite = w; pwdata = d; tx_rd = r; clear = c;
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] d);
    cyc(1'b1, 1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    chk(tag, {24'h0, txdata}, {24'h0, exp});
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    // reset
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("rst_count", {29'h0, tx_count}, 32'd0);
    chk("rst_empty", {31'h0, tx_empty}, 32'd1);
    chk("rst_intr", {31'h0, ssptxintr}, 32'd0);
    chk("rst_txdata", {24'h0, txdata}, 32'h00);
`ifdef SSP_TX_FIFO_ERR_EN
    chk("rst_ovf", {31'h0, tx_ovf}, 32'd0);
    chk("rst_udf", {31'h0, tx_udf}, 32'd0);
`endif

    // basic order
    wr(8'hA1); wr(8'hB2); wr(8'hC3);
    chk("basic_count", {29'h0, tx_count}, 32'd3);
    chk("basic_head", {24'h0, txdata}, 32'hA1);
    cyc(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    chk("apb_read_noeffect", {29'h0, tx_count}, 32'd3);
    pop_expect("basic_pop0", 8'hA1);
    pop_expect("basic_pop1", 8'hB2);
    pop_expect("basic_pop2", 8'hC3);
    idle();
    chk("basic_empty", {31'h0, tx_empty}, 32'd1);
    chk("basic_txdata0", {24'h0, txdata}, 32'h00);

    // fill to full, overflow dropped
    wr(8'h01); wr(8'h02); wr(8'h03);
    chk("fill3_intr", {31'h0, ssptxintr}, 32'd0);
    wr(8'h04);
    chk("full_intr", {31'h0, ssptxintr}, 32'd1);
    chk("full_count", {29'h0, tx_count}, 32'd4);
    wr(8'h05);
    chk("ovf_count", {29'h0, tx_count}, 32'd4);
`ifdef SSP_TX_FIFO_ERR_EN
    chk("ovf_flag", {31'h0, tx_ovf}, 32'd1);
`endif
    pop_expect("full_pop0", 8'h01);
    chk("full_intr_drop", {31'h0, ssptxintr}, 32'd0);
    pop_expect("full_pop1", 8'h02);
    pop_expect("full_pop2", 8'h03);
    pop_expect("full_pop3", 8'h04);
    idle();
    chk("full_drained", {31'h0, tx_empty}, 32'd1);
`ifdef SSP_TX_FIFO_ERR_EN
    chk("ovf_sticky", {31'h0, tx_ovf}, 32'd1);
`endif

    // push and pop together while full
    wr(8'h10); wr(8'h11); wr(8'h12); wr(8'h13);
    cyc(1'b1, 1'b1, 8'h14, 1'b1, 1'b0);
    chk("full_pp_count", {29'h0, tx_count}, 32'd4);
    pop_expect("full_pp_pop0", 8'h11);
    pop_expect("full_pp_pop1", 8'h12);
    pop_expect("full_pp_pop2", 8'h13);
    pop_expect("full_pp_pop3", 8'h14);
    idle();

    // push and pop together while empty: push only, no bypass
    cyc(1'b1, 1'b1, 8'h20, 1'b1, 1'b0);
    chk("empty_pp_count", {29'h0, tx_count}, 32'd1);
    chk("empty_pp_data", {24'h0, txdata}, 32'h20);
    pop_expect("empty_pp_pop", 8'h20);
    idle();

    // underflow
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      chk("udf_count", {29'h0, tx_count}, 32'd0);
    end
    wr(8'h55);
    chk("udf_then_wr_data", {24'h0, txdata}, 32'h55);
    chk("udf_then_wr_count", {29'h0, tx_count}, 32'd1);
`ifdef SSP_TX_FIFO_ERR_EN
    chk("udf_flag", {31'h0, tx_udf}, 32'd1);
`endif
    pop_expect("udf_pop", 8'h55);
    idle();

    // wrap-around: push, push, pop pattern against a bounded queue model
    model_q.delete();
    for (int k = 0; k < 10; k++) begin
      wr(8'h60 + 8'(k));
      if (model_q.size() < 4) model_q.push_back(8'h60 + 8'(k));
      chk("wrap_push_count", {29'h0, tx_count}, model_q.size());
      if (k % 2 == 1) begin
        pop_expect("wrap_pop", model_q.pop_front());
        chk("wrap_pop_count", {29'h0, tx_count}, model_q.size());
      end
    end
    while (model_q.size() > 0) pop_expect("wrap_drain", model_q.pop_front());
    idle();
    chk("wrap_empty", {31'h0, tx_empty}, 32'd1);

    // clear in the same cycle as push and pop
    wr(8'h71); wr(8'h72); wr(8'h73);
    cyc(1'b1, 1'b1, 8'h74, 1'b1, 1'b1);
    chk("midrst_count", {29'h0, tx_count}, 32'd0);
    chk("midrst_empty", {31'h0, tx_empty}, 32'd1);
    chk("midrst_intr", {31'h0, ssptxintr}, 32'd0);
    chk("midrst_txdata", {24'h0, txdata}, 32'h00);
`ifdef SSP_TX_FIFO_ERR_EN
    chk("midrst_ovf", {31'h0, tx_ovf}, 32'd0);
    chk("midrst_udf", {31'h0, tx_udf}, 32'd0);
`endif
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
